store_trace_checker: RTL

- Synthesizable, parametrised self-checking monitor for the RISC-V core's data-memory store port (MemWrite / dataadr / WriteData).
- Holds a loadable table of up to DEPTH expected stores and compares each observed store, in order, against the table.
- Reports pass, fail or timeout, with diagnostics.
- Replaces manual waveform inspection of final stores in top-level benches; also usable on FPGA with status outputs tied to LEDs.

---
 rtl/store_trace_checker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/store_trace_checker.sv
// In-order checker for the core's data-memory store port against a loadable table of expected stores.
// Define STORE_FILTER_EN to compare only stores whose address falls inside [FILT_BASE, FILT_BASE+FILT_SIZE).
module store_trace_checker #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int FILT_BASE   = 0,
   parameter int FILT_SIZE   = 256,
   localparam int IDX_W      = $clog2(DEPTH),
   localparam int CNT_W      = $clog2(TIMEOUT_CYC) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [XLEN-1:0]  cfg_adr,
   input  logic [XLEN-1:0]  cfg_data,
   input  logic [IDX_W:0]   cfg_num,
   input  logic             start,
   input  logic             clear,
   input  logic             MemWrite,
   input  logic [XLEN-1:0]  dataadr,
   input  logic [XLEN-1:0]  WriteData,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [IDX_W-1:0] err_idx,
   output logic [XLEN-1:0]  err_adr,
   output logic [XLEN-1:0]  err_data,
   output logic [IDX_W:0]   match_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   // state  | meaning
   // S_IDLE | table writable, waiting for start
   // S_RUN  | comparing observed stores against table[r_ptr]
   // S_PASS | all expected stores matched
   // S_FAIL | a store mismatched; err_* hold the offending store
   // S_TMO  | cycle limit reached before all stores seen
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

`ifdef STORE_FILTER_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif

   state_t           r_state;
   logic [XLEN-1:0]  r_tab_adr [DEPTH];
   logic [XLEN-1:0]  r_tab_dat [DEPTH];
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   r_num;

   logic [XLEN-1:0]  w_off;
   logic             w_in_win;
   logic             w_store;
   logic             w_hit;
   logic             w_last;
   logic             w_limit;
   logic [IDX_W:0]   w_num_clamp;

   // An address below the base wraps to a large offset, so one compare covers both bounds.
   assign w_off       = dataadr - XLEN'(FILT_BASE);
   assign w_in_win    = (w_off < XLEN'(FILT_SIZE));
   assign w_store     = MemWrite & (w_in_win | ~FILT_ON);
   assign w_hit       = (dataadr == r_tab_adr[r_ptr]) && (WriteData == r_tab_dat[r_ptr]);
   assign w_last      = ({1'b0, r_ptr} == (r_num - (IDX_W+1)'(1)));
   assign w_limit     = (cycle_cnt >= CNT_W'(TIMEOUT_CYC - 1));
   assign w_num_clamp = (cfg_num > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : cfg_num;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tab_adr[i] <= '0;
            r_tab_dat[i] <= '0;
         end
      end else if (r_state == S_IDLE && cfg_we) begin
         r_tab_adr[cfg_idx] <= cfg_adr;
         r_tab_dat[cfg_idx] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_num     <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
         err_idx   <= '0;
         err_adr   <= '0;
         err_data  <= '0;
         match_cnt <= '0;
         cycle_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ptr     <= '0;
                  r_num     <= w_num_clamp;
                  match_cnt <= '0;
                  cycle_cnt <= '0;
                  err_idx   <= '0;
                  err_adr   <= '0;
                  err_data  <= '0;
                  if (w_num_clamp == '0) begin
                     r_state <= S_PASS;
                     done    <= 1'b1;
                     pass    <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (cycle_cnt != '1)
                  cycle_cnt <= cycle_cnt + CNT_W'(1);
               if (w_store && w_hit) begin
                  match_cnt <= match_cnt + (IDX_W+1)'(1);
                  if (w_last) begin
                     r_state <= S_PASS;
                     done    <= 1'b1;
                     pass    <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + IDX_W'(1);
                     // A matching store at the limit still times out, pointing at the next entry.
                     if (w_limit) begin
                        r_state  <= S_TMO;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        err_idx  <= r_ptr + IDX_W'(1);
                        err_adr  <= '0;
                        err_data <= '0;
                     end
                  end
               end else if (w_store) begin
                  r_state  <= S_FAIL;
                  done     <= 1'b1;
                  fail     <= 1'b1;
                  err_idx  <= r_ptr;
                  err_adr  <= dataadr;
                  err_data <= WriteData;
               end else if (w_limit) begin
                  r_state  <= S_TMO;
                  done     <= 1'b1;
                  timeout  <= 1'b1;
                  err_idx  <= r_ptr;
                  err_adr  <= '0;
                  err_data <= '0;
               end
            end
            S_PASS, S_FAIL, S_TMO: begin
               if (clear) begin
                  r_state <= S_IDLE;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  fail    <= 1'b0;
                  timeout <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
